// File: rtl/fpm_norm_round.sv
// fpm_norm_round: normalise, round-to-nearest-even and pack the FP multiplier product into IEEE-754 single precision.
module fpm_norm_round #(
    parameter int          EXP_W       = 10,
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [47:0]      mant,
    input  logic             in_zero,
    input  logic             in_inf,
    input  logic             in_nan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             overflow,
    output logic             underflow,
    output logic             inexact
);
    localparam logic signed [EXP_W:0] EMAX = (EXP_W+1)'(255);
    localparam logic signed [EXP_W:0] EMIN = '0;

    logic                    s1_valid_q, s1_sign_q, s1_guard_q, s1_sticky_q;
    logic                    s1_zero_q, s1_inf_q, s1_nan_q;
    logic [22:0]             s1_frac_q, s1_frac_d;
    logic                    s1_guard_d, s1_sticky_d;
    logic signed [EXP_W:0]   s1_exp_q, s1_exp_d;
    logic                    s2_valid_q, overflow_q, underflow_q, inexact_q;
    logic [31:0]             result_q, result_d;
    logic                    overflow_d, underflow_d, inexact_d;
    logic                    s1_adv, s2_adv, round_up, special;
    logic [23:0]             sum;
    logic signed [EXP_W:0]   e2;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_frac_d   = mant[47] ? mant[46:24] : mant[45:23];
        s1_guard_d  = mant[47] ? mant[23] : mant[22];
        s1_sticky_d = mant[47] ? |mant[22:0] : |mant[21:0];
        s1_exp_d    = $signed({exp_in[EXP_W-1], exp_in}) + $signed({{EXP_W{1'b0}}, mant[47]});
        round_up    = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
        sum         = {1'b0, s1_frac_q} + {23'b0, round_up};
        // a carry out of the rounded fraction leaves sum[22:0] all zero, exactly the renormalised fraction
        e2          = s1_exp_q + $signed({{EXP_W{1'b0}}, sum[23]});
        special     = s1_nan_q | s1_inf_q | s1_zero_q;
        overflow_d  = !special && (e2 >= EMAX);
        underflow_d = !special && !overflow_d && (e2 <= EMIN);
        inexact_d   = overflow_d | underflow_d | (!special & (s1_guard_q | s1_sticky_q));
        result_d    = (s1_nan_q | (s1_inf_q & s1_zero_q)) ? NAN_PATTERN :
                      (s1_inf_q | overflow_d)             ? {s1_sign_q, 8'hFF, 23'h0} :
                      (s1_zero_q | underflow_d)           ? {s1_sign_q, 31'h0} :
                                                            {s1_sign_q, e2[7:0], sum[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_frac_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_nan_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q  <= in_valid;
                s1_sign_q   <= sign;
                s1_frac_q   <= s1_frac_d;
                s1_guard_q  <= s1_guard_d;
                s1_sticky_q <= s1_sticky_d;
                s1_exp_q    <= s1_exp_d;
                s1_zero_q   <= in_zero;
                s1_inf_q    <= in_inf;
                s1_nan_q    <= in_nan;
            end
            if (s2_adv) begin
                s2_valid_q  <= s1_valid_q;
                result_q    <= result_d;
                overflow_q  <= overflow_d;
                underflow_q <= underflow_d;
                inexact_q   <= inexact_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;
endmodule

// File: tb/tb_fpm_norm_round.sv
// tb_fpm_norm_round: directed vector table plus backpressure and mid-flight reset sequences for fpm_norm_round.
module tb_fpm_norm_round;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, sign = 1'b0;
    logic [9:0]  exp_in = '0;
    logic [47:0] mant = '0;
    logic        in_zero = 1'b0, in_inf = 1'b0, in_nan = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] result;
    logic        overflow, underflow, inexact;
    int          checks = 0, errors = 0;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [47:0] m;
        logic        z, i, n;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;
    vec_t vt[18];

    fpm_norm_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sign(sign),
        .exp_in(exp_in), .mant(mant), .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        sign = v.s; exp_in = v.e; mant = v.m; in_zero = v.z; in_inf = v.i; in_nan = v.n;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int k);
        int n;
        drive(vt[k]);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 6) begin
            step();
            n++;
            @(negedge clk);
        end
        chk($sformatf("latency[%0d]", k), n, 2);
        chk($sformatf("result[%0d]", k), result, vt[k].res);
        chk($sformatf("flags[%0d]", k), {29'b0, overflow, underflow, inexact}, {29'b0, vt[k].fl});
        step();
    endtask

    initial begin
        int bp[4];
        int sent, got, cyc;
        logic seen_fall;
        // flags field is {overflow, underflow, inexact}
        vt[0]  = '{0, 10'd127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 3'b000};
        vt[1]  = '{0, 10'd127, 48'h900000000000, 0, 0, 0, 32'h40100000, 3'b000};
        vt[2]  = '{0, 10'd127, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 3'b001};
        vt[3]  = '{0, 10'd127, 48'h400000400000, 0, 0, 0, 32'h3F800000, 3'b001};
        vt[4]  = '{0, 10'd127, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 3'b001};
        vt[5]  = '{0, 10'd254, 48'h800000000000, 0, 0, 0, 32'h7F800000, 3'b101};
        vt[6]  = '{1, 10'd0,   48'h400000000000, 0, 0, 0, 32'h80000000, 3'b011};
        vt[7]  = '{0, 10'd127, 48'h400000000000, 0, 0, 1, 32'h7FC00000, 3'b000};
        vt[8]  = '{1, 10'd127, 48'h400000000000, 1, 1, 0, 32'h7FC00000, 3'b000};
        vt[9]  = '{0, 10'd254, 48'h400000000000, 0, 0, 0, 32'h7F000000, 3'b000};
        vt[10] = '{0, 10'd1,   48'h400000000000, 0, 0, 0, 32'h00800000, 3'b000};
        vt[11] = '{1, 10'd127, 48'h000000000000, 1, 0, 0, 32'h80000000, 3'b000};
        vt[12] = '{1, 10'd127, 48'h400000000000, 0, 1, 0, 32'hFF800000, 3'b000};
        vt[13] = '{0, 10'd127, 48'h400000400001, 0, 0, 0, 32'h3F800001, 3'b001};
        vt[14] = '{0, 10'd127, 48'h400000000001, 0, 0, 0, 32'h3F800000, 3'b001};
        vt[15] = '{0, 10'h3FB, 48'h800000000000, 0, 0, 0, 32'h00000000, 3'b011};
        vt[16] = '{0, 10'd254, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 3'b101};
        vt[17] = '{1, 10'h3FF, 48'h800000000000, 0, 0, 0, 32'h80000000, 3'b011};

        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {29'b0, overflow, underflow, inexact}, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        step();

        for (int k = 0; k < 18; k++) run_vec(k);

        // four back-to-back beats against a stalled output
        bp = '{0, 1, 2, 4};
        sent = 0; got = 0; seen_fall = 1'b0;
        out_ready = 1'b0;
        for (cyc = 0; cyc < 40 && got < 4; cyc++) begin
            in_valid = (sent < 4);
            if (sent < 4) drive(vt[bp[sent]]);
            out_ready = (cyc >= 6);
            @(negedge clk);
            if (sent == 2 && !out_ready && !seen_fall) begin
                chk("bp_in_ready_fall", {31'b0, in_ready}, 0);
                seen_fall = 1'b1;
            end
            if (cyc == 5) chk("bp_hold_result", result, vt[bp[0]].res);
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order[%0d]", got), result, vt[bp[got]].res);
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_count", got, 4);
        chk("bp_fall_seen", {31'b0, seen_fall}, 1);
        step();
        @(negedge clk);
        chk("bp_no_dup", {31'b0, out_valid}, 0);
        step();

        // reset while two beats are in flight
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(vt[k]);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_flight_out_valid", {31'b0, out_valid}, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) chk("rst_stale_beat", {31'b0, out_valid}, 0);
            step();
        end
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        run_vec(13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
